// File: rtl/qos_pkg.sv
// ---------------------------------------------------------------------------
// qos_pkg
// Shared constants and types for the QoS scheduler slice.
//   NUM_Q    : number of input queues served by the scheduler
//   QID_W    : width of a queue index
//   CREDIT_W : width of one per-queue weighted round-robin credit counter
//   state_t  : scheduler FSM states (IDLE waits for a slot, SERVE holds a word)
//   oneHot() : queue index to one-hot pop vector
// ---------------------------------------------------------------------------
package qos_pkg;

   localparam int NUM_Q    = 4;
   localparam int QID_W    = 2;
   localparam int CREDIT_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   function automatic logic [NUM_Q-1:0] oneHot(input logic [QID_W-1:0] idx);
      return NUM_Q'(1) << idx;
   endfunction

endpackage

// File: rtl/qos_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder. Starting at i_ptr and searching
// upward with wrap, returns the first set bit of i_req.
//   i_req   : request vector, one bit per queue
//   i_ptr   : index where the search starts (highest priority this cycle)
//   o_idx   : index of the winning request (0 when nothing is requested)
//   o_found : high when any request bit is set
// ---------------------------------------------------------------------------
module rr_pick
   import qos_pkg::*;
(
   input  logic [NUM_Q-1:0] i_req,
   input  logic [QID_W-1:0] i_ptr,
   output logic [QID_W-1:0] o_idx,
   output logic             o_found
);

   // Walk the candidates in priority order; the first hit locks the result.
   always_comb begin
      logic [QID_W-1:0] cand;
      cand    = '0;
      o_idx   = '0;
      o_found = 1'b0;
      for (int k = 0; k < NUM_Q; k++) begin
         cand = i_ptr + QID_W'(k);
         if (!o_found && i_req[cand]) begin
            o_idx   = cand;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/qos_scheduler.sv
// ---------------------------------------------------------------------------
// qos_scheduler
// Weighted round-robin scheduler for four show-ahead queues. One service slot
// opens every TICK_DIV clocks; in a slot the scheduler pops one queue head,
// registers it on the output and holds it until the consumer accepts it.
//
// Ports
//   clock     : sole clock, rising edge
//   reset_n   : asynchronous active-low reset
//   req       : bit q high = queue q has a valid head word
//   q_data    : head word of queue q on bits [q*DATA_W +: DATA_W]
//   deq       : one-hot, one-clock pop strobe to the granted queue
//   out_valid : out_data/out_qid hold a served word
//   out_data  : served word
//   out_qid   : queue that supplied out_data
//   out_ready : consumer accepts the word when high together with out_valid
//
// Build option
//   QOS_STRICT_PRIO_EN : when defined, the lowest-index requesting queue always
//                        wins and credits / rr pointer stay at reset values.
// ---------------------------------------------------------------------------
module qos_scheduler
   import qos_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int TICK_DIV = 4,
   parameter int W0       = 4,
   parameter int W1       = 3,
   parameter int W2       = 2,
   parameter int W3       = 1
)(
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NUM_Q-1:0]        req,
   input  logic [NUM_Q*DATA_W-1:0] q_data,
   output logic [NUM_Q-1:0]        deq,
   output logic                    out_valid,
   output logic [DATA_W-1:0]       out_data,
   output logic [QID_W-1:0]        out_qid,
   input  logic                    out_ready
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [NUM_Q*CREDIT_W-1:0] WEIGHTS =
      {CREDIT_W'(W3), CREDIT_W'(W2), CREDIT_W'(W1), CREDIT_W'(W0)};

   function automatic logic [CREDIT_W-1:0] weightOf(input logic [QID_W-1:0] q);
      return WEIGHTS[q*CREDIT_W +: CREDIT_W];
   endfunction

   state_t                r_state;
   state_t                w_nextState;
   logic [CNT_W-1:0]      r_tickCnt;
   logic [QID_W-1:0]      r_rrPtr;
   logic [CREDIT_W-1:0]   r_credit [NUM_Q];
   logic [NUM_Q-1:0]      r_deq;
   logic                  r_outValid;
   logic [DATA_W-1:0]     r_outData;
   logic [QID_W-1:0]      r_outQid;

   logic                  w_tick;
   logic                  w_grant;
   logic [NUM_Q-1:0]      w_pickReq;
   logic [QID_W-1:0]      w_pickPtr;
   logic [QID_W-1:0]      w_pickIdx;
   logic                  w_pickFound;

   // Free-running slot counter; it keeps counting while a word is held.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_tickCnt <= '0;
      end else if (r_tickCnt == TICK_LAST) begin
         r_tickCnt <= '0;
      end else begin
         r_tickCnt <= r_tickCnt + CNT_W'(1);
      end
   end

   assign w_tick = (r_tickCnt == TICK_LAST);

`ifdef QOS_STRICT_PRIO_EN
   assign w_pickReq = req;
   assign w_pickPtr = '0;
`else
   logic [NUM_Q-1:0] w_elig;
   logic             w_eligEmpty;

   // Queues that still have credit this round; when none do, the round is
   // over and the pick falls back to raw requests while credits reload.
   always_comb begin
      w_elig = '0;
      for (int q = 0; q < NUM_Q; q++) begin
         w_elig[q] = req[q] && (r_credit[q] != '0);
      end
   end

   assign w_eligEmpty = (w_elig == '0);
   assign w_pickReq   = w_eligEmpty ? req : w_elig;
   assign w_pickPtr   = r_rrPtr;
`endif

   rr_pick u_pick (
      .i_req   (w_pickReq),
      .i_ptr   (w_pickPtr),
      .o_idx   (w_pickIdx),
      .o_found (w_pickFound)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A grant needs an open slot and at least one request; a held word is
   // released only by the consumer, and slots are ignored meanwhile.
   always_comb begin
      w_nextState = r_state;
      w_grant     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_tick && w_pickFound) begin
               w_grant     = 1'b1;
               w_nextState = SERVE;
            end
         end
         SERVE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Output register: capture the granted head and pop the queue for a single
   // clock; the captured word stays put until accepted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_deq      <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
         r_outQid   <= '0;
      end else begin
         r_deq <= '0;
         if (w_grant) begin
            r_deq      <= oneHot(w_pickIdx);
            r_outValid <= 1'b1;
            r_outData  <= q_data[w_pickIdx*DATA_W +: DATA_W];
            r_outQid   <= w_pickIdx;
         end else if ((r_state == SERVE) && out_ready) begin
            r_outValid <= 1'b0;
         end
      end
   end

   // Credit and rotation bookkeeping. On a reload grant the winner starts the
   // new round already charged for this grant.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_rrPtr <= '0;
         for (int q = 0; q < NUM_Q; q++) begin
            r_credit[q] <= weightOf(QID_W'(q));
         end
      end else begin
`ifdef QOS_STRICT_PRIO_EN
         r_rrPtr <= r_rrPtr;
         for (int q = 0; q < NUM_Q; q++) begin
            r_credit[q] <= r_credit[q];
         end
`else
         if (w_grant) begin
            r_rrPtr <= w_pickIdx + QID_W'(1);
            if (w_eligEmpty) begin
               for (int q = 0; q < NUM_Q; q++) begin
                  r_credit[q] <= weightOf(QID_W'(q));
               end
               r_credit[w_pickIdx] <= weightOf(w_pickIdx) - CREDIT_W'(1);
            end else begin
               r_credit[w_pickIdx] <= r_credit[w_pickIdx] - CREDIT_W'(1);
            end
         end
`endif
      end
   end

   assign deq       = r_deq;
   assign out_valid = r_outValid;
   assign out_data  = r_outData;
   assign out_qid   = r_outQid;

endmodule

// File: tb/tb_qos_scheduler.sv
// ---------------------------------------------------------------------------
// tb_qos_scheduler
// Self-checking bench for qos_scheduler with default parameters
// (DATA_W=8, TICK_DIV=4, weights 4,3,2,1). Expected grants come from a table
// of hand-derived weighted round-robin sequences and are queued in a
// scoreboard as each request pattern is driven, then popped when the DUT
// pops a queue. Hand-written sequences cover the held-output and
// reset-during-serve corner cases.
// ---------------------------------------------------------------------------
module tb_qos_scheduler;

   localparam int DATA_W   = 8;
   localparam int TICK_DIV = 4;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  req     = '0;
   logic [31:0] qData   = '0;
   logic        outReady = 1'b1;
   logic [3:0]  deq;
   logic        outValid;
   logic [7:0]  outData;
   logic [1:0]  outQid;

   qos_scheduler #(
      .DATA_W   (DATA_W),
      .TICK_DIV (TICK_DIV),
      .W0       (4),
      .W1       (3),
      .W2       (2),
      .W3       (1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .q_data    (qData),
      .deq       (deq),
      .out_valid (outValid),
      .out_data  (outData),
      .out_qid   (outQid),
      .out_ready (outReady)
   );

   always #5 clock = ~clock;

   int cycle = 0;
   always @(posedge clock) cycle <= cycle + 1;

   typedef struct {
      bit         rst;
      logic [3:0] req;
      logic [1:0] expQid;
      string      grp;
   } vec_t;

   typedef struct {
      logic [1:0] qid;
      logic [7:0] data;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   int checks    = 0;
   int failures  = 0;
   int lastGrant = 0;

   // Weighted round-robin order for req=1111 from reset with weights 4,3,2,1.
   logic [1:0] wrrAll [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2,
                               2'd0, 2'd1, 2'd0, 2'd1};

   // Under strict priority the lowest requesting queue always wins.
   function automatic logic [1:0] expFor(input logic [3:0] r, input logic [1:0] wrrQid);
`ifdef QOS_STRICT_PRIO_EN
      for (int q = 0; q < 4; q++) begin
         if (r[q]) return 2'(q);
      end
      return 2'd0;
`else
      return (r == 4'b0) ? 2'd0 : wrrQid;
`endif
   endfunction

   function automatic logic [7:0] headWord(input int tag, input int q);
      return 8'((tag * 7 + q * 41 + 3) % 256);
   endfunction

   function automatic void addVec(input bit rst, input logic [3:0] r,
                                  input logic [1:0] q, input string grp);
      vec_t v;
      v.rst    = rst;
      v.req    = r;
      v.expQid = expFor(r, q);
      v.grp    = grp;
      vecs.push_back(v);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                  name, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input int tag, input logic [3:0] r,
                                input logic [1:0] expQid);
      exp_t e;
      req = r;
      for (int q = 0; q < 4; q++) begin
         qData[q*8 +: 8] = headWord(tag, q);
      end
      e.qid  = expQid;
      e.data = headWord(tag, expQid);
      sb.push_back(e);
   endtask

   task automatic doReset(input string name);
      req     = '0;
      reset_n = 1'b0;
      #1;
      checkOutput({name, " reset deq"},       32'(deq),      32'h0);
      checkOutput({name, " reset out_valid"}, 32'(outValid), 32'h0);
      checkOutput({name, " reset out_data"},  32'(outData),  32'h0);
      checkOutput({name, " reset out_qid"},   32'(outQid),   32'h0);
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Wait (bounded) for the next pop strobe, then compare against the
   // oldest scoreboard entry.
   task automatic collectGrant(input string name, input bit checkSpacing);
      bit   got;
      exp_t e;
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(posedge clock);
         #1;
         if (deq != 4'b0) got = 1'b1;
      end
      if (!got) begin
         checkOutput({name, " grant timeout"}, 32'h0, 32'h1);
         if (sb.size() != 0) void'(sb.pop_front());
         return;
      end
      if (sb.size() == 0) begin
         checkOutput({name, " unexpected grant"}, 32'(deq), 32'h0);
         return;
      end
      e = sb.pop_front();
      checkOutput({name, " out_qid"},   32'(outQid),   32'(e.qid));
      checkOutput({name, " out_data"},  32'(outData),  32'(e.data));
      checkOutput({name, " deq"},       32'(deq),      32'(4'b0001 << e.qid));
      checkOutput({name, " out_valid"}, 32'(outValid), 32'h1);
      if (checkSpacing) begin
         checkOutput({name, " grant spacing"}, 32'(cycle - lastGrant), 32'(TICK_DIV));
      end
      lastGrant = cycle;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit first;

      // Single queue 0: one pop per slot, through a credit reload.
      for (int i = 0; i < 5; i++) addVec(i == 0, 4'b0001, 2'd0, "q0only");
      // All queues busy: weighted order and the reload on the 11th grant.
      for (int i = 0; i < 11; i++) addVec(i == 0, 4'b1111, wrrAll[i], "wrr1111");
      // Queue 2 alone across several reloads, no slot lost.
      for (int i = 0; i < 6; i++) addVec(i == 0, 4'b0100, 2'd2, "q2only");
      // Mixed patterns exercising skip of exhausted credit and wrap.
      addVec(1'b1, 4'b1010, 2'd1, "mixed");
      addVec(1'b0, 4'b1010, 2'd3, "mixed");
      addVec(1'b0, 4'b1010, 2'd1, "mixed");
      addVec(1'b0, 4'b1001, 2'd0, "mixed");
      addVec(1'b0, 4'b1000, 2'd3, "mixed");
      addVec(1'b0, 4'b0110, 2'd1, "mixed");
      addVec(1'b0, 4'b0110, 2'd2, "mixed");
      addVec(1'b0, 4'b0011, 2'd0, "mixed");

      outReady = 1'b1;
      first    = 1'b1;
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rst) begin
            doReset(vecs[i].grp);
            first = 1'b1;
         end
         applyStimulus(i, vecs[i].req, vecs[i].expQid);
         collectGrant(vecs[i].grp, !first);
         first = 1'b0;
      end

      // Held word: consumer stalls for 20 clocks while the queue heads change.
      doReset("hold");
      outReady = 1'b0;
      applyStimulus(50, 4'b0100, expFor(4'b0100, 2'd2));
      collectGrant("hold", 1'b0);
      for (int q = 0; q < 4; q++) qData[q*8 +: 8] = headWord(51, q);
      for (int i = 0; i < 20; i++) begin
         @(posedge clock);
         #1;
         checkOutput("hold out_valid", 32'(outValid), 32'h1);
         checkOutput("hold out_qid",   32'(outQid),   32'h2);
         checkOutput("hold out_data",  32'(outData),  32'(headWord(50, 2)));
         checkOutput("hold deq",       32'(deq),      32'h0);
      end
      req      = '0;
      outReady = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("hold accept out_valid", 32'(outValid), 32'h0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clock);
         #1;
         checkOutput("after accept out_valid", 32'(outValid), 32'h0);
         checkOutput("after accept deq",       32'(deq),      32'h0);
      end

      // Reset while serving: credits and pointer must restart from scratch.
      doReset("midrst");
      outReady = 1'b1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(60 + i, 4'b1111, expFor(4'b1111, wrrAll[i]));
         collectGrant("midrst pre", i != 0);
      end
      @(posedge clock);
      #1;
      outReady = 1'b0;
      applyStimulus(66, 4'b1111, expFor(4'b1111, wrrAll[6]));
      collectGrant("midrst held", 1'b1);
      #2;
      doReset("midrst async");
      outReady = 1'b1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(70 + i, 4'b1111, expFor(4'b1111, wrrAll[i]));
         collectGrant("midrst post", i != 0);
      end

      checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/qos_scheduler.md
QOS_SCHEDULER -- requirements
Module: qos_scheduler

Interface
REQ-001 Parameter DATA_W, default 8: width of one queue head word.
REQ-002 Parameter TICK_DIV, default 4: service slot period in clocks (matches pixel-enable divide).
REQ-003 Parameters W0, W1, W2, W3, defaults 4, 3, 2, 1: per-queue weights; legal range 1..15.
REQ-004 clock  input  1  sole clock, all state on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  4  bit q high = queue q non-empty (show-ahead head valid).
REQ-007 q_data  input  4*DATA_W  head word of queue q on bits [q*DATA_W +: DATA_W].
REQ-008 deq  output  4  one-hot, one-clock pop strobe to queue q.
REQ-009 out_valid  output  1  out_data/out_qid hold a served word.
REQ-010 out_data  output  DATA_W  served word.
REQ-011 out_qid  output  2  index of queue that supplied out_data.
REQ-012 out_ready  input  1  consumer (display path) accepts word when high with out_valid.

Function
REQ-013 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick is high in the cycle the count equals TICK_DIV-1.
REQ-014 FSM SHALL have two states: IDLE and SERVE.
REQ-015 IDLE, tick high, req != 0: at that edge register grant q, deq = onehot(q) for exactly one clock, out_data = q_data slice q, out_qid = q, out_valid = 1, credit[q] decremented, rr pointer = (q+1) mod 4, go SERVE.
REQ-016 IDLE with tick low or req == 0: no grant, no deq, outputs unchanged.
REQ-017 SERVE: out_valid, out_data and out_qid SHALL stay stable until out_ready is high; at that edge out_valid = 0, go IDLE.
REQ-018 SERVE: deq SHALL be 0 and ticks SHALL be ignored (tick counter keeps running).
REQ-019 Eligible set = req AND (credit != 0); q = first eligible index searching upward from rr pointer with wrap.
REQ-020 If req != 0 and eligible set is empty at a grant edge: all credits reload to weights, selection uses req, and the granted queue ends at weight-1, all in the same edge.
REQ-021 Credits are 4-bit unsigned, never decremented below 0.
REQ-022 At most one deq bit high per clock; deq never high for a queue whose req is low.
REQ-023 Minimum grant spacing is TICK_DIV clocks; grant throughput is one word per tick when out_ready is held high.

Reset
REQ-024 reset_n low SHALL immediately force: state IDLE, tick counter 0, rr pointer 0, credits = W0..W3, deq = 0, out_valid = 0, out_data = 0, out_qid = 0.
REQ-025 Reset mid-SERVE discards the held word; no deq is issued for it again after reset.

Configuration
REQ-026 Macro QOS_STRICT_PRIO_EN defined: q = lowest-index requesting queue; credits and rr pointer are held at reset values.
REQ-027 Macro QOS_STRICT_PRIO_EN undefined: weighted round robin per REQ-019/020.

Structure
REQ-028 Package qos_pkg SHALL hold NUM_Q = 4, QID_W = 2, CREDIT_W = 4 and the FSM state enum.
REQ-029 Sub-module rr_pick: combinational rotating priority encoder (4-bit request, 2-bit pointer in; 2-bit index and found flag out).

Verification
REQ-030 req=0001, out_ready=1, TICK_DIV=4: one deq[0] pulse every 4 clocks, out_qid=0, out_data equals queue 0 head each time.
REQ-031 req=1111 constant, default weights, out_ready=1: first 10 out_qid values 0,1,2,3,0,1,2,0,1,0, reload on the 11th grant, which is queue 1.
REQ-032 One grant pending, out_ready=0 for 20 clocks: out_valid=1 and out_data/out_qid stable throughout, deq=0 throughout; single accept on out_ready=1.
REQ-033 reset_n pulsed low during SERVE: out_valid and deq go 0 without a clock edge, credits read 4,3,2,1, next grant with req=1111 is queue 0.
REQ-034 req=0100 only, W2=2: queue 2 is served on every tick across credit reloads, with no tick lost.
REQ-035 QOS_STRICT_PRIO_EN defined: req=1111 gives only out_qid=0; req=1010 gives only out_qid=1.
